// File: rtl/gpr_ctx_engine.sv
// gpr_ctx_engine - context save/restore engine for the GPR file.
//
// This block is the master of the GPR read and write buses. While idle it
// passes CPU pipeline traffic straight through. On a command it takes both
// buses and does one of two things:
//   save    : reads a contiguous, wrapping GPR range and streams it out (so_*)
//   restore : accepts a word stream (ri_*) and writes it into a GPR range
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   cmd_valid/ready/op/first/count
//                            command handshake (op 0=save, 1=restore)
//   busy, done               engine owns the buses / one-cycle completion pulse
//   so_valid/ready/data/last save output stream
//   ri_valid/ready/data      restore input stream
//   pl_rd_addr_*, pl_rd_data_*, pl_wr_*
//                            pipeline side of the GPR buses
//   gpr_rd_addr_*, gpr_rd_data_*, gpr_wr_*
//                            GPR file side (write enable is active-low)
module gpr_ctx_engine #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int GPR_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_first,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              busy,
  output logic              done,
  output logic              so_valid,
  input  logic              so_ready,
  output logic [DATA_W-1:0] so_data,
  output logic              so_last,
  input  logic              ri_valid,
  output logic              ri_ready,
  input  logic [DATA_W-1:0] ri_data,
  input  logic [ADDR_W-1:0] pl_rd_addr_0,
  input  logic [ADDR_W-1:0] pl_rd_addr_1,
  output logic [DATA_W-1:0] pl_rd_data_0,
  output logic [DATA_W-1:0] pl_rd_data_1,
  input  logic [ADDR_W-1:0] pl_wr_addr,
  input  logic [DATA_W-1:0] pl_wr_data,
  input  logic              pl_wr_we_,
  output logic [ADDR_W-1:0] gpr_rd_addr_0,
  output logic [ADDR_W-1:0] gpr_rd_addr_1,
  input  logic [DATA_W-1:0] gpr_rd_data_0,
  input  logic [DATA_W-1:0] gpr_rd_data_1,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data,
  output logic              gpr_wr_we_
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   NUM_C   = (ADDR_W+1)'(GPR_NUM);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   ZERO_C  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] PTR1_C  = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                so_valid_q, so_valid_d;
  logic                so_last_q, so_last_d;
  logic [DATA_W-1:0]   so_data_q, so_data_d;

  logic [ADDR_W:0]     count_clamped_s;
  logic                load_s;
  logic                ri_accept_s;
  logic                ri_ready_s;
  logic                idle_s;

  // Command length clamp and per-state helper decodes.
  always_comb begin
    if (cmd_count > NUM_C) begin
      count_clamped_s = NUM_C;
    end else begin
      count_clamped_s = cmd_count;
    end
    idle_s = (state_q == ST_IDLE);
    // Reset gates the restore handshake so no write slips out in the reset cycle.
    ri_ready_s  = (state_q == ST_RESTORE) && (rem_q != ZERO_C) && !rst;
    ri_accept_s = ri_valid && ri_ready_s;
    // A new save beat can be captured whenever the output slot is empty or draining.
    load_s = (state_q == ST_SAVE) && (rem_q != ZERO_C) && (!so_valid_q || so_ready);
  end

  // Next-state logic for the FSM, pointer, counter and save output register.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    so_valid_d = so_valid_q;
    so_last_d  = so_last_q;
    so_data_d  = so_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ptr_d = cmd_first;
          rem_d = count_clamped_s;
          if (count_clamped_s == ZERO_C) begin
            state_d = ST_DONE;
          end else if (cmd_op) begin
            state_d = ST_RESTORE;
          end else begin
            state_d = ST_SAVE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE: begin
        if (load_s) begin
          so_data_d  = gpr_rd_data_0;
          so_valid_d = 1'b1;
          so_last_d  = (rem_q == ONE_C);
          ptr_d      = ptr_q + PTR1_C;
          rem_d      = rem_q - ONE_C;
        end else if (so_valid_q && so_ready) begin
          so_valid_d = 1'b0;
          // Only the last beat can drain without a reload, but test it explicitly.
          if (so_last_q) begin
            so_last_d = 1'b0;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_SAVE;
          end
        end else begin
          state_d = ST_SAVE;
        end
      end
      ST_RESTORE: begin
        if (ri_accept_s) begin
          ptr_d = ptr_q + PTR1_C;
          rem_d = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RESTORE;
          end
        end else begin
          state_d = ST_RESTORE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      so_valid_q <= 1'b0;
      so_last_q  <= 1'b0;
      so_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      so_valid_q <= so_valid_d;
      so_last_q  <= so_last_d;
      so_data_q  <= so_data_d;
    end
  end

  // Bus ownership: pass-through when idle, engine-driven (pipeline isolated) otherwise.
  always_comb begin
    gpr_rd_addr_1 = pl_rd_addr_1;
    if (idle_s) begin
      gpr_rd_addr_0 = pl_rd_addr_0;
      pl_rd_data_0  = gpr_rd_data_0;
      pl_rd_data_1  = gpr_rd_data_1;
      gpr_wr_addr   = pl_wr_addr;
      gpr_wr_data   = pl_wr_data;
      gpr_wr_we_    = pl_wr_we_;
    end else begin
      gpr_rd_addr_0 = ptr_q;
      pl_rd_data_0  = '0;
      pl_rd_data_1  = '0;
      gpr_wr_addr   = ptr_q;
      gpr_wr_data   = ri_data;
      gpr_wr_we_    = !ri_accept_s;
    end
  end

  // Status and stream outputs decoded from registered state.
  always_comb begin
    cmd_ready = idle_s;
    busy      = (state_q == ST_SAVE) || (state_q == ST_RESTORE);
    done      = (state_q == ST_DONE);
    ri_ready  = ri_ready_s;
    so_valid  = so_valid_q;
    so_last   = so_last_q;
    so_data   = so_data_q;
  end

endmodule

// File: tb/tb_gpr_ctx_engine.sv
module tb_gpr_ctx_engine;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [AW-1:0] cmd_first = '0;
  logic [AW:0]   cmd_count = '0;
  logic          busy, done;
  logic          so_valid, so_last;
  logic          so_ready = 1'b1;
  logic [DW-1:0] so_data;
  logic          ri_valid = 1'b0;
  logic          ri_ready;
  logic [DW-1:0] ri_data = '0;
  logic [AW-1:0] pl_rd_addr_0 = '0, pl_rd_addr_1 = '0;
  logic [DW-1:0] pl_rd_data_0, pl_rd_data_1;
  logic [AW-1:0] pl_wr_addr = '0;
  logic [DW-1:0] pl_wr_data = '0;
  logic          pl_wr_we_ = 1'b1;
  logic [AW-1:0] gpr_rd_addr_0, gpr_rd_addr_1;
  logic [DW-1:0] gpr_rd_data_0, gpr_rd_data_1;
  logic [AW-1:0] gpr_wr_addr;
  logic [DW-1:0] gpr_wr_data;
  logic          gpr_wr_we_;

  always #5 clk = ~clk;

  gpr_ctx_engine #(.ADDR_W(AW), .DATA_W(DW), .GPR_NUM(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_first(cmd_first), .cmd_count(cmd_count),
    .busy(busy), .done(done),
    .so_valid(so_valid), .so_ready(so_ready), .so_data(so_data), .so_last(so_last),
    .ri_valid(ri_valid), .ri_ready(ri_ready), .ri_data(ri_data),
    .pl_rd_addr_0(pl_rd_addr_0), .pl_rd_addr_1(pl_rd_addr_1),
    .pl_rd_data_0(pl_rd_data_0), .pl_rd_data_1(pl_rd_data_1),
    .pl_wr_addr(pl_wr_addr), .pl_wr_data(pl_wr_data), .pl_wr_we_(pl_wr_we_),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data), .gpr_wr_we_(gpr_wr_we_)
  );

  // GPR file environment: registered write, combinational write-bypassed read.
  logic [DW-1:0] gpr_mem [N];
  always @(posedge clk) begin
    if (!gpr_wr_we_) gpr_mem[gpr_wr_addr] <= gpr_wr_data;
  end
  assign gpr_rd_data_0 = (!gpr_wr_we_ && gpr_wr_addr == gpr_rd_addr_0) ? gpr_wr_data : gpr_mem[gpr_rd_addr_0];
  assign gpr_rd_data_1 = (!gpr_wr_we_ && gpr_wr_addr == gpr_rd_addr_1) ? gpr_wr_data : gpr_mem[gpr_rd_addr_1];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] exp_gpr [N];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_beats = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every visible save beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (so_valid) begin
      if (sb.size() == 0) begin
        chk("so_extra_beat", {63'd0, so_valid}, 64'd0);
      end else begin
        chk("so_data", so_data, sb[0].data);
        chk("so_last", so_last, sb[0].last);
        if (so_ready) begin
          void'(sb.pop_front());
          n_beats++;
        end
      end
    end
  end

  task automatic send_cmd(input logic op, input logic [AW-1:0] first, input logic [AW:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_first = first;
    cmd_count = cnt;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_save(input int first, input int cnt);
    int n;
    beat_t b;
    n = (cnt > N) ? N : cnt;
    for (int k = 0; k < n; k++) begin
      b.data = exp_gpr[(first + k) % N];
      b.last = (k == n - 1);
      sb.push_back(b);
    end
  endtask

  // mode 0: so_ready held high; mode 1: so_ready pattern 1,0,0 repeating.
  // pl_wr: drive a pipeline write to r5 while the engine is busy.
  task automatic run_save(input int first, input int cnt, input int mode, input bit pl_wr,
                          output int busy_cyc, output int first_cyc, output int done_cyc);
    push_save(first, cnt);
    send_cmd(1'b0, AW'(first), (AW+1)'(cnt));
    busy_cyc = 0; first_cyc = -1; done_cyc = -1;
    pl_rd_addr_0 = 5'd5;
    for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
      so_ready = (mode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      if (pl_wr) begin
        pl_wr_we_ = 1'b0; pl_wr_addr = 5'd5; pl_wr_data = 32'hBAD0BAD0;
      end
      #1;
      if (busy) begin
        busy_cyc++;
        chk("pl_rd_isolated", pl_rd_data_0, 0);
        chk("pl_wr_suppressed", gpr_wr_we_, 1);
      end
      if (so_valid && first_cyc < 0) first_cyc = c;
      if (done) begin
        done_cyc  = c;
        pl_wr_we_ = 1'b1;
      end
      tick();
    end
    so_ready  = 1'b1;
    pl_wr_we_ = 1'b1;
    chk("save_done_seen", {63'd0, done_cyc > 0}, 64'd1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, fc, dc, nb0;
    logic [DW-1:0] rd_d [4];
    logic          rd_v [4];
    rd_v = '{1'b1, 1'b0, 1'b0, 1'b1};
    rd_d = '{32'hDEADBEEF, 32'h0, 32'h0, 32'hCAFEF00D};

    // Reset values
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_so_valid", so_valid, 0);
    chk("rst_so_last", so_last, 0);
    chk("rst_so_data", so_data, 0);
    chk("rst_ri_ready", ri_ready, 0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Preload r0..r31 through pass-through writes
    for (int i = 0; i < N; i++) begin
      pl_wr_we_ = 1'b0; pl_wr_addr = AW'(i); pl_wr_data = 32'h100 + i;
      exp_gpr[i] = 32'h100 + i;
      if (i == 3) begin
        #1;
        chk("pass_wr_we", gpr_wr_we_, 0);
        chk("pass_wr_addr", gpr_wr_addr, 3);
        chk("pass_wr_data", gpr_wr_data, 32'h103);
      end
      tick();
    end
    pl_wr_we_ = 1'b1;

    // Save first=4 count=3, ready high, pipeline write to r5 attempted meanwhile
    run_save(4, 3, 0, 1'b1, bc, fc, dc);
    chk("save1_busy_cycles", bc, 4);
    chk("save1_first_valid_cycle", fc, 2);
    chk("save1_done_cycle", dc, 5);
    pl_rd_addr_0 = 5'd5; pl_rd_addr_1 = 5'd6;
    #1;
    chk("r5_unchanged_passthru", pl_rd_data_0, 32'h105);
    chk("r6_passthru_port1", pl_rd_data_1, 32'h106);
    tick();

    // Wrapping save with so_ready stalls
    run_save(30, 4, 1, 1'b0, bc, fc, dc);

    // count=0 is a no-op that still pulses done
    send_cmd(1'b0, 5'd7, 6'd0);
    pl_wr_we_ = 1'b0; pl_wr_addr = 5'd7; pl_wr_data = 32'h0;
    #1;
    chk("nop_done", done, 1);
    chk("nop_busy", busy, 0);
    chk("nop_so_valid", so_valid, 0);
    chk("nop_no_write", gpr_wr_we_, 1);
    chk("done_cmd_ready", cmd_ready, 0);
    pl_wr_we_ = 1'b1;
    tick();
    chk("nop_done_pulse_end", done, 0);
    chk("nop_back_idle", cmd_ready, 1);

    // count=40 clamps to 32 beats
    nb0 = n_beats;
    run_save(0, 40, 0, 1'b0, bc, fc, dc);
    chk("clamp_beats", n_beats - nb0, 32);

    // Restore first=31 count=2 with a 2-cycle ri_valid gap
    send_cmd(1'b1, 5'd31, 6'd2);
    for (int c = 0; c < 4; c++) begin
      ri_valid = rd_v[c]; ri_data = rd_d[c];
      #1;
      chk("rs_ri_ready", ri_ready, 1);
      chk("rs_we_only_on_accept", gpr_wr_we_, {63'd0, !rd_v[c]});
      if (rd_v[c]) begin
        chk("rs_wr_addr", gpr_wr_addr, (c == 0) ? 64'd31 : 64'd0);
        chk("rs_wr_data", gpr_wr_data, rd_d[c]);
      end
      tick();
    end
    ri_valid = 1'b0;
    #1;
    chk("rs_done", done, 1);
    chk("rs_ri_ready_off", ri_ready, 0);
    tick();
    exp_gpr[31] = 32'hDEADBEEF; exp_gpr[0] = 32'hCAFEF00D;
    pl_rd_addr_0 = 5'd31; pl_rd_addr_1 = 5'd0;
    #1;
    chk("rs_r31", pl_rd_data_0, 32'hDEADBEEF);
    chk("rs_r0", pl_rd_data_1, 32'hCAFEF00D);
    tick();

    // Reset in the middle of a 5-beat restore after 2 beats
    send_cmd(1'b1, 5'd10, 6'd5);
    for (int c = 0; c < 2; c++) begin
      ri_valid = 1'b1; ri_data = 32'hA0 + c;
      tick();
    end
    rst = 1'b1; ri_valid = 1'b1; ri_data = 32'hFF;
    #1;
    chk("rst_cycle_no_write", gpr_wr_we_, 1);
    tick();
    rst = 1'b0; ri_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_so_valid", so_valid, 0);
    chk("abort_ri_ready", ri_ready, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    tick();
    exp_gpr[10] = 32'hA0; exp_gpr[11] = 32'hA1;
    // New command after abort: r10, r11 restored, r12 untouched
    run_save(10, 3, 0, 1'b0, bc, fc, dc);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_ctx_engine.md
Name: gpr_ctx_engine

Overview:
- Context save/restore engine; the master side of the GPR read and write buses.
- On a command it either reads a contiguous, wrapping range of GPRs and streams the values out (save), or accepts a word stream and writes it into a GPR range (restore).
- Sits between the CPU pipeline and the GPR file: passes pipeline traffic through when idle, owns both buses when busy.
- Used by the exception/trap unit and the debug module.

Parameters:
ADDR_W, 5, GPR address width
DATA_W, 32, word width
GPR_NUM, 32, number of GPRs (= 2**ADDR_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  1  0=save, 1=restore
cmd_first  in  ADDR_W  first GPR index
cmd_count  in  ADDR_W+1  number of registers; 0 = no-op; >GPR_NUM clamped to GPR_NUM
busy  out  1  engine owns the GPR buses; pipeline must stall
done  out  1  one-cycle completion pulse
so_valid  out  1  save stream beat valid
so_ready  in  1  save stream sink ready
so_data  out  DATA_W  saved GPR value
so_last  out  1  final beat of the save
ri_valid  in  1  restore stream beat valid
ri_ready  out  1  restore stream ready
ri_data  in  DATA_W  value to restore
pl_rd_addr_0, pl_rd_addr_1  in  ADDR_W  pipeline read addresses
pl_rd_data_0, pl_rd_data_1  out  DATA_W  pipeline read data
pl_wr_addr  in  ADDR_W  pipeline write address
pl_wr_data  in  DATA_W  pipeline write data
pl_wr_we_  in  1  pipeline write enable, active-low
gpr_rd_addr_0, gpr_rd_addr_1  out  ADDR_W  to GPR read bus
gpr_rd_data_0, gpr_rd_data_1  in  DATA_W  from GPR read bus (combinational, write-bypassed)
gpr_wr_addr  out  ADDR_W  to GPR write bus
gpr_wr_data  out  DATA_W  to GPR write bus
gpr_wr_we_  out  1  to GPR write bus, active-low (0 = write)

Behaviour:
- States: IDLE, SAVE, RESTORE, DONE.
- Reset: state=IDLE; so_valid=0, so_last=0, so_data=0; done=0; busy=0; ptr=0; remaining=0.
- Reset mid-operation aborts immediately. No further writes occur, and any pending so beat is dropped. GPRs already written keep their values.
- IDLE:
  - cmd_ready=1, busy=0, ri_ready=0.
  - Pass-through: gpr_rd_addr_x=pl_rd_addr_x, pl_rd_data_x=gpr_rd_data_x, gpr_wr_*=pl_wr_*.
  - On cmd accept: ptr<=cmd_first, remaining<=clamped cmd_count. Next state is DONE if count==0, else SAVE (op=0) or RESTORE (op=1).
- SAVE, RESTORE and DONE (pipeline isolation):
  - busy=1 in SAVE/RESTORE, 0 in DONE.
  - cmd_ready=0.
  - Pipeline writes suppressed: gpr_wr_we_=1 unless the engine is writing.
  - pl_rd_data_x=0. gpr_rd_addr_1=pl_rd_addr_1 (unused).
- SAVE:
  - gpr_rd_addr_0=ptr.
  - Load condition: remaining>0 and (!so_valid || so_ready). On load: so_data<=gpr_rd_data_0, so_valid<=1, so_last<=(remaining==1), ptr<=ptr+1 mod GPR_NUM, remaining<=remaining-1.
  - If so_valid&&so_ready and no load: so_valid<=0.
  - Exit when a beat with so_last is accepted: so_valid<=0, -> DONE.
  - Throughput: 1 beat/cycle with so_ready held high.
  - Latency: first so_valid in the 2nd cycle after the cmd handshake.
  - so_data/so_last hold stable while so_valid&&!so_ready.
- RESTORE:
  - ri_ready=(remaining>0).
  - On ri_valid&&ri_ready, in the same cycle (combinational): gpr_wr_we_=0, gpr_wr_addr=ptr, gpr_wr_data=ri_data; then ptr++ mod GPR_NUM, remaining--.
  - Accepting the last beat -> DONE. The write lands at that edge.
  - ri_valid low inserts bubbles with no side effect.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in this cycle.
- Address wrap: ptr wraps from GPR_NUM-1 to 0 (e.g. first=30, count=4 -> 30,31,0,1).
- No write ever occurs from the pipeline while busy, so the GPR read bypass never alters saved data.

Test Plan:
- Reset, then preload r0..r31 = 0x100+i via pipeline writes; save first=4 count=3 with so_ready=1 -> so beats 0x104, 0x105, 0x106, last on 3rd; done 1 cycle after; busy high 4 cycles.
- Save first=30 count=4 with so_ready toggling 1,0,0,1,... -> beats 0x11E, 0x11F, 0x100, 0x101; data stable while stalled; no drops or duplicates.
- Restore first=31 count=2 with data 0xDEADBEEF, 0xCAFEF00D and a 2-cycle ri_valid gap -> r31=0xDEADBEEF, r0=0xCAFEF00D; gpr_wr_we_ low only on accept cycles.
- Pipeline write to r5 (pl_wr_we_=0) issued during save -> gpr_wr_we_ stays 1; r5 unchanged; pl_rd_data=0 while busy; pass-through restored in IDLE.
- cmd_count=0 -> DONE next cycle, done pulse, no so beats, no writes; cmd_count=40 -> exactly 32 beats.
- rst asserted mid-restore after 2 of 5 beats -> outputs to reset values next cycle; only the first 2 registers modified; new command accepted afterwards.
